// File: rtl/instr_encoder.sv
// instr_encoder: turns decoded instruction requests into 32-bit MIPS-style
// words and appends them to an instruction memory, one word per 3 cycles.
// Flow per request: IDLE (accept) -> ENC (build word) -> WRITE (strobe).
module instr_encoder #(
   parameter int DEPTH = 64,
   parameter int AW    = 6
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [3:0]    kind,
   input  logic [4:0]    rs,
   input  logic [4:0]    rt,
   input  logic [4:0]    rd,
   input  logic [15:0]   imm,
   input  logic [25:0]   target,
   input  logic          clear,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wd,
   output logic [AW:0]   count,
   output logic          full,
   output logic          err
);

   // instruction classes
   localparam logic [3:0] K_ADD  = 4'd0;
   localparam logic [3:0] K_SUB  = 4'd1;
   localparam logic [3:0] K_AND  = 4'd2;
   localparam logic [3:0] K_OR   = 4'd3;
   localparam logic [3:0] K_SLT  = 4'd4;
   localparam logic [3:0] K_LW   = 4'd5;
   localparam logic [3:0] K_SW   = 4'd6;
   localparam logic [3:0] K_BEQ  = 4'd7;
   localparam logic [3:0] K_ADDI = 4'd8;
   localparam logic [3:0] K_J    = 4'd9;

   // primary opcodes
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // R-type function codes
   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ENC   = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t state, state_nxt;

   // captured request fields
   logic [3:0]  kind_r;
   logic [4:0]  rs_r, rt_r, rd_r;
   logic [15:0] imm_r;
   logic [25:0] target_r;

   logic        accept;
   logic        kind_legal;
   logic [31:0] enc_word;

   assign accept     = req_valid & req_ready;
   assign kind_legal = (kind_r <= K_J);
   assign full       = (count == DEPTH_C);
   assign imem_addr  = count[AW-1:0];

   // state register; reset and clear both abandon any request in flight
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else if (clear)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // next-state: illegal kinds bail out of ENC without reaching WRITE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = ENC;
         ENC:     state_nxt = kind_legal ? WRITE : IDLE;
         WRITE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // outputs: write strobe is masked by clear/reset so a dropped request
   // never reaches the memory, even mid-WRITE
   always_comb begin
      req_ready = (state == IDLE) & ~full & ~clear & ~reset;
      imem_we   = (state == WRITE) & ~clear & ~reset;
   end

   // capture request fields at acceptance; they are only read in ENC
   always_ff @(posedge clk) begin
      if (reset) begin
         kind_r   <= '0;
         rs_r     <= '0;
         rt_r     <= '0;
         rd_r     <= '0;
         imm_r    <= '0;
         target_r <= '0;
      end else if (accept) begin
         kind_r   <= kind;
         rs_r     <= rs;
         rt_r     <= rt;
         rd_r     <= rd;
         imm_r    <= imm;
         target_r <= target;
      end
   end

   // encoder: each format only picks the fields it owns, so unused inputs
   // cannot leak into the word
   always_comb begin
      enc_word = '0;
      case (kind_r)
         K_ADD:  enc_word = {OP_RTYPE, rs_r, rt_r, rd_r, 5'b00000, FN_ADD};
         K_SUB:  enc_word = {OP_RTYPE, rs_r, rt_r, rd_r, 5'b00000, FN_SUB};
         K_AND:  enc_word = {OP_RTYPE, rs_r, rt_r, rd_r, 5'b00000, FN_AND};
         K_OR:   enc_word = {OP_RTYPE, rs_r, rt_r, rd_r, 5'b00000, FN_OR};
         K_SLT:  enc_word = {OP_RTYPE, rs_r, rt_r, rd_r, 5'b00000, FN_SLT};
         K_LW:   enc_word = {OP_LW,   rs_r, rt_r, imm_r};
         K_SW:   enc_word = {OP_SW,   rs_r, rt_r, imm_r};
         K_BEQ:  enc_word = {OP_BEQ,  rs_r, rt_r, imm_r};
         K_ADDI: enc_word = {OP_ADDI, rs_r, rt_r, imm_r};
         K_J:    enc_word = {OP_J, target_r};
         default: enc_word = '0;
      endcase
   end

   // write data: loaded once per legal request in ENC, held otherwise
   always_ff @(posedge clk) begin
      if (reset)
         imem_wd <= '0;
      else if (!clear && state == ENC && kind_legal)
         imem_wd <= enc_word;
   end

   // fill counter advances as the WRITE cycle closes
   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (state == WRITE)
         count <= count + 1'b1;
   end

   // sticky illegal-kind flag
   always_ff @(posedge clk) begin
      if (reset)
         err <= 1'b0;
      else if (clear)
         err <= 1'b0;
      else if (state == ENC && !kind_legal)
         err <= 1'b1;
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed requests with literal expectations plus a
// latency-based reference model compared against the outputs every cycle.
module tb_instr_encoder;

   localparam int DEPTH = 64;
   localparam int AW    = 6;

   logic          clk = 0;
   logic          reset = 1;
   logic          req_valid = 0;
   logic          req_ready;
   logic [3:0]    kind = 0;
   logic [4:0]    rs = 0, rt = 0, rd = 0;
   logic [15:0]   imm = 0;
   logic [25:0]   target = 0;
   logic          clear = 0;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wd;
   logic [AW:0]   count;
   logic          full;
   logic          err;

   int total = 0;
   int bad   = 0;

   instr_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .kind(kind), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .target(target),
      .clear(clear), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wd(imem_wd), .count(count), .full(full), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Word formats by table lookup; a request occupies the unit for a fixed
   // number of cycles after acceptance (left = cycles until it is done).
   localparam logic [5:0] OPC [0:9] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                        6'h23, 6'h2b, 6'h04, 6'h08, 6'h02};
   localparam logic [5:0] FNC [0:4] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

   function automatic logic [31:0] model_enc(input int k, input logic [4:0] s,
      input logic [4:0] t, input logic [4:0] d, input logic [15:0] im, input logic [25:0] tg);
      if (k <= 4)      return {6'd0, s, t, d, 5'd0, FNC[k]};
      else if (k <= 8) return {OPC[k], s, t, im};
      else             return {OPC[9], tg};
   endfunction

   int          m_count = 0;
   logic        m_err = 0;
   logic [31:0] m_wd = 0;
   int          m_left = 0;
   logic [31:0] m_word = 0;
   logic        m_legal = 0;
   logic        started = 0;
   logic        exp_ready, exp_we;

   assign exp_ready = (m_left == 0) && (m_count != DEPTH) && !clear && !reset;
   assign exp_we    = (m_left == 1) && !clear && !reset;

   always @(posedge clk) begin
      started <= 1'b1;
      if (reset) begin
         m_count <= 0; m_err <= 0; m_wd <= 0; m_left <= 0;
      end else if (clear) begin
         m_count <= 0; m_err <= 0; m_left <= 0;
      end else if (m_left == 0) begin
         if (req_valid && exp_ready) begin
            m_left  <= 2;
            m_legal <= (kind <= 9);
            m_word  <= (kind <= 9) ? model_enc(int'(kind), rs, rt, rd, imm, target) : 32'h0;
         end
      end else if (m_left == 2) begin
         if (m_legal) begin m_wd <= m_word; m_left <= 1; end
         else begin m_err <= 1'b1; m_left <= 0; end
      end else begin
         m_count <= m_count + 1;
         m_left  <= 0;
      end
   end

   // every-cycle comparison against the model
   always @(negedge clk) begin
      if (started) begin
         chk("ready", 32'(req_ready), 32'(exp_ready));
         chk("we",    32'(imem_we),   32'(exp_we));
         chk("count", 32'(count),     32'(m_count));
         chk("full",  32'(full),      32'(m_count == DEPTH));
         chk("err",   32'(err),       32'(m_err));
         chk("wd",    imem_wd,        m_wd);
         chk("addr",  32'(imem_addr), 32'(m_count % DEPTH));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_req(input logic [3:0] k, input logic [4:0] s, input logic [4:0] t,
                         input logic [4:0] d, input logic [15:0] im, input logic [25:0] tg);
      bit got;
      got = 0;
      @(posedge clk); #1;
      kind = k; rs = s; rt = t; rd = d; imm = im; target = tg;
      req_valid = 1;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         if (req_ready) begin
            @(posedge clk); #1;
            got = 1;
         end
      end
      req_valid = 0;
      if (!got) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   // waits for the write strobe; n = negedges waited (0 on timeout)
   task automatic wait_write(output int n, output logic [31:0] wd, output logic [31:0] addr);
      n = 0; wd = 0; addr = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (imem_we) begin
            n = i; wd = imem_wd; addr = 32'(imem_addr);
            break;
         end
      end
      if (n == 0) chk("write_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_clear();
      @(posedge clk); #1 clear = 1;
      @(posedge clk); #1 clear = 0;
   endtask

   int          n;
   logic [31:0] wd, addr;

   initial begin
      // reset
      repeat (2) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_wd", imem_wd, 32'h0);
      chk("rst_ready", 32'(req_ready), 32'd1);

      // ADD $8,$17,$18
      do_req(4'd0, 5'd17, 5'd18, 5'd8, 16'h0, 26'h0);
      wait_write(n, wd, addr);
      chk("add_lat", 32'(n), 32'd2);
      chk("add_wd", wd, 32'h02324020);
      chk("add_addr", addr, 32'd0);
      @(negedge clk);
      chk("add_count", 32'(count), 32'd1);
      chk("add_we_once", 32'(imem_we), 32'd0);

      // LW / BEQ from an empty memory, junk in unused fields
      do_clear();
      do_req(4'd5, 5'd0, 5'd2, 5'd31, 16'h0050, 26'h3ffffff);
      wait_write(n, wd, addr);
      chk("lw_wd", wd, 32'h8C020050);
      chk("lw_addr", addr, 32'd0);
      do_req(4'd7, 5'd4, 5'd5, 5'd17, 16'hFFFF, 26'h2aaaaaa);
      wait_write(n, wd, addr);
      chk("beq_wd", wd, 32'h1085FFFF);
      chk("beq_addr", addr, 32'd1);

      // J with junk register/immediate fields
      do_req(4'd9, 5'd31, 5'd31, 5'd31, 16'hABCD, 26'h0000011);
      wait_write(n, wd, addr);
      chk("j_wd", wd, 32'h08000011);
      chk("j_addr", addr, 32'd2);

      // illegal kind: no write, sticky err, wd kept
      do_req(4'd12, 5'd1, 5'd2, 5'd3, 16'h1234, 26'h0);
      repeat (3) @(negedge clk);
      chk("ill_err", 32'(err), 32'd1);
      chk("ill_count", 32'(count), 32'd3);
      chk("ill_wd_kept", imem_wd, 32'h08000011);
      do_req(4'd8, 5'd3, 5'd4, 5'd0, 16'h0007, 26'h0);
      wait_write(n, wd, addr);
      chk("addi_wd", wd, 32'h20640007);
      chk("addi_addr", addr, 32'd3);
      @(negedge clk);
      chk("err_sticky", 32'(err), 32'd1);
      do_clear();
      @(negedge clk);
      chk("clr_err", 32'(err), 32'd0);

      // fill to DEPTH, hold a pending request, clear and drain it
      for (int i = 0; i < DEPTH; i++)
         do_req(4'(i % 10), 5'(i), 5'(i + 1), 5'(i + 2), 16'(i * 3), 26'(i));
      repeat (3) @(negedge clk);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_count", 32'(count), 32'd64);
      @(posedge clk); #1;
      kind = 4'd1; rs = 5'd9; rt = 5'd10; rd = 5'd11; req_valid = 1;
      repeat (4) begin
         @(negedge clk);
         chk("full_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clk); #1 clear = 1;
      @(negedge clk);
      chk("clr_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1 clear = 0;
      @(negedge clk);
      chk("post_clr_count", 32'(count), 32'd0);
      chk("post_clr_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1 req_valid = 0;
      wait_write(n, wd, addr);
      chk("pend_lat", 32'(n), 32'd2);
      chk("pend_wd", wd, 32'h012A5822);
      chk("pend_addr", addr, 32'd0);

      // reset during WRITE
      do_req(4'd3, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
      @(posedge clk); #1 reset = 1;   // now in WRITE
      @(negedge clk);
      chk("rstw_we", 32'(imem_we), 32'd0);
      chk("rstw_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1 reset = 0;
      @(negedge clk);
      chk("rstw_we2", 32'(imem_we), 32'd0);
      chk("rstw_wd", imem_wd, 32'h0);
      chk("rstw_count", 32'(count), 32'd0);
      chk("rstw_full", 32'(full), 32'd0);
      chk("rstw_err", 32'(err), 32'd0);
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning the number of instruction-memory words that can be filled.
REQ-002 SHALL have parameter AW, default 6, meaning the instruction-memory address width, with DEPTH <= 2**AW.
REQ-003 SHALL have port clk, input, 1, meaning the single clock, rising-edge active.
REQ-004 SHALL have port reset, input, 1, meaning a synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, 1, meaning an encode request is present.
REQ-006 SHALL have port req_ready, output, 1, meaning a request can be accepted.
REQ-007 SHALL have port kind, input, 4, meaning the instruction class: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 LW, 6 SW, 7 BEQ, 8 ADDI, 9 J; 10-15 are illegal.
REQ-008 SHALL have ports rs, rt and rd, each input, 5, meaning the register fields.
REQ-009 SHALL have port imm, input, 16, meaning the immediate/offset field.
REQ-010 SHALL have port target, input, 26, meaning the jump target field.
REQ-011 SHALL have port clear, input, 1, meaning restart fill at address 0.
REQ-012 SHALL have port imem_we, output, 1, meaning the instruction-memory write strobe.
REQ-013 SHALL have port imem_addr, output, AW, meaning the write address, always equal to count[AW-1:0].
REQ-014 SHALL have port imem_wd, output, 32, meaning the encoded instruction word.
REQ-015 SHALL have port count, output, AW+1, meaning the number of words written.
REQ-016 SHALL have port full, output, 1, meaning count == DEPTH.
REQ-017 SHALL have port err, output, 1, meaning sticky flag for an illegal kind.

Function
REQ-018 SHALL implement the FSM IDLE -> ENC -> WRITE -> IDLE; a request is accepted when req_valid & req_ready are both high at a rising edge.
REQ-019 SHALL drive req_ready = (state == IDLE) & !full & !clear & !reset.
REQ-020 SHALL, on acceptance, register kind and all fields, then enter ENC.
REQ-021 SHALL, in ENC, register the encoded word into imem_wd and enter WRITE for a legal kind; for an illegal kind it SHALL set err, leave imem_wd unchanged and return to IDLE without writing.
REQ-022 SHALL hold imem_we = 1 for exactly the single WRITE cycle, increment count at the closing edge of that cycle, and return to IDLE; write latency is 2 cycles from acceptance, and throughput is one request per 3 cycles.
REQ-023 SHALL encode R-type kinds 0-4 as op 000000, rs, rt, rd, shamt 00000, with funct ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010.
REQ-024 SHALL encode I-type kinds as op & rs & rt & imm, with op LW 100011, SW 101011, BEQ 000100, ADDI 001000; rd is ignored.
REQ-025 SHALL encode J as op 000010 & target; rs, rt, rd and imm are ignored.
REQ-026 SHALL ensure that unused fields never influence imem_wd.
REQ-027 SHALL, when full is high, hold req_ready at 0; a pending request stays pending, and count never exceeds DEPTH.
REQ-028 SHALL, when clear is high in any state, at the next edge return the FSM to IDLE and set count = 0 and err = 0; any in-flight request is dropped without a write, and imem_we is forced to 0 during the clear cycle.
REQ-029 SHALL give clear priority when clear and req_valid are asserted together; no request is accepted in that cycle.
REQ-030 SHALL leave imem_wd holding the last encoded word while in IDLE.

Reset
REQ-031 SHALL, while reset is high at a rising edge, set state to IDLE, imem_we to 0, imem_wd to 0, count to 0, full to 0 and err to 0; req_ready SHALL be 0 while reset is asserted.
REQ-032 SHALL have reset override clear and any in-flight request, including one in ENC or WRITE, which SHALL be dropped without a write.

Verification
REQ-033 SHALL cover: kind=0, rs=17, rt=18, rd=8 -> imem_wd=0x02324020, imem_addr=0, imem_we high for 1 cycle 2 cycles after acceptance, count=1.
REQ-034 SHALL cover: kind=5, rs=0, rt=2, imm=0x0050 (with rd=31 as junk) -> 0x8C020050; then kind=7, rs=4, rt=5, imm=0xFFFF -> 0x1085FFFF at addr 1.
REQ-035 SHALL cover: kind=9, target=0x0000011 (with rs/rt/imm as junk) -> 0x08000011.
REQ-036 SHALL cover: kind=12 -> err=1, no imem_we, count unchanged; a following legal request is still written, and err stays 1 until clear or reset.
REQ-037 SHALL cover: 64 back-to-back requests -> full=1, count=64, req_ready=0 with the 65th request held pending; then clear -> count=0, and the pending request is accepted only after clear is released and written at addr 0.
REQ-038 SHALL cover: reset asserted in the WRITE cycle -> no memory write occurs, and all outputs match the REQ-031 reset values on the following cycle.
